// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: 8-entry register file feeding a pipeline register that drives the ALU inputs.
// Optional feature macro WRITE_BYPASS_EN: same-cycle write forwarding and refresh of stalled operands.
module alu_operand_stage #(
   parameter int regSize  = 8,
   parameter int regCount = 8,
   localparam int AW      = $clog2(regCount)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               InValid,
   output logic               InReady,
   input  logic [AW-1:0]      RdAddrA,
   input  logic [AW-1:0]      RdAddrB,
   input  logic               ImmSel,
   input  logic [regSize-1:0] Imm,
   input  logic [2:0]         ALUOpIn,
   input  logic [AW-1:0]      DestIn,
   input  logic               WrEn,
   input  logic [AW-1:0]      WrAddr,
   input  logic [regSize-1:0] WrData,
   input  logic               Stall,
   input  logic               Flush,
   output logic [regSize-1:0] SrcA,
   output logic [regSize-1:0] SrcB,
   output logic [2:0]         ALUOp,
   output logic [AW-1:0]      DestOut,
   output logic               OutValid
);

   logic [regSize-1:0] regFile [regCount];
   logic [regSize-1:0] readA, readB, opA, opB;
   logic [regSize-1:0] srcANxt, srcBNxt;
   logic [2:0]         aluOpNxt;
   logic [AW-1:0]      destNxt;
   logic               validNxt;

   assign InReady = !Stall;

   // Writeback port is independent of stall and flush
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < regCount; i++) regFile[i] <= '0;
      end else if (WrEn) begin
         regFile[WrAddr] <= WrData;
      end
   end

   always_comb begin
      readA = regFile[RdAddrA];
      readB = regFile[RdAddrB];
`ifdef WRITE_BYPASS_EN
      if (WrEn && WrAddr == RdAddrA) readA = WrData;
      if (WrEn && WrAddr == RdAddrB) readB = WrData;
`endif
      opA = readA;
      opB = ImmSel ? Imm : readB;
   end

`ifdef WRITE_BYPASS_EN
   logic [AW-1:0] heldAddrA, heldAddrB;
   logic          heldImmSel;

   // Source addresses of the held instruction, used to refresh operands during a stall
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         heldAddrA  <= '0;
         heldAddrB  <= '0;
         heldImmSel <= 1'b0;
      end else if (Flush || (!Stall && !InValid)) begin
         heldAddrA  <= '0;
         heldAddrB  <= '0;
         heldImmSel <= 1'b0;
      end else if (!Stall) begin
         heldAddrA  <= RdAddrA;
         heldAddrB  <= RdAddrB;
         heldImmSel <= ImmSel;
      end
   end
`endif

   // Flush beats stall; an empty slot is carried down as an all-zero payload
   always_comb begin
      srcANxt  = SrcA;
      srcBNxt  = SrcB;
      aluOpNxt = ALUOp;
      destNxt  = DestOut;
      validNxt = OutValid;
      if (Flush || (!Stall && !InValid)) begin
         srcANxt  = '0;
         srcBNxt  = '0;
         aluOpNxt = 3'b000;
         destNxt  = '0;
         validNxt = 1'b0;
      end else if (!Stall) begin
         srcANxt  = opA;
         srcBNxt  = opB;
         aluOpNxt = ALUOpIn;
         destNxt  = DestIn;
         validNxt = 1'b1;
      end
`ifdef WRITE_BYPASS_EN
      else if (OutValid && WrEn) begin
         if (WrAddr == heldAddrA) srcANxt = WrData;
         if (WrAddr == heldAddrB && !heldImmSel) srcBNxt = WrData;
      end
`endif
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         SrcA     <= '0;
         SrcB     <= '0;
         ALUOp    <= 3'b000;
         DestOut  <= '0;
         OutValid <= 1'b0;
      end else begin
         SrcA     <= srcANxt;
         SrcB     <= srcBNxt;
         ALUOp    <= aluOpNxt;
         DestOut  <= destNxt;
         OutValid <= validNxt;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic against a behavioural model.
// Follows WRITE_BYPASS_EN the same way the design does.
module tb_alu_operand_stage;

   localparam int regSize  = 8;
   localparam int regCount = 8;
   localparam int AW       = 3;

   logic               Clk = 1'b0;
   logic               Reset_n;
   logic               InValid, InReady, ImmSel, WrEn, Stall, Flush, OutValid;
   logic [AW-1:0]      RdAddrA, RdAddrB, DestIn, WrAddr, DestOut;
   logic [regSize-1:0] Imm, WrData, SrcA, SrcB;
   logic [2:0]         ALUOpIn, ALUOp;

   int checkCount = 0;
   int failCount  = 0;

   alu_operand_stage #(.regSize(regSize), .regCount(regCount)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
      .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .ImmSel(ImmSel), .Imm(Imm),
      .ALUOpIn(ALUOpIn), .DestIn(DestIn), .WrEn(WrEn), .WrAddr(WrAddr),
      .WrData(WrData), .Stall(Stall), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB),
      .ALUOp(ALUOp), .DestOut(DestOut), .OutValid(OutValid)
   );

   always #5 Clk = ~Clk;

   // Reference model: architectural register contents plus the instruction sitting at the ALU inputs
   typedef struct packed {
      logic               valid;
      logic [regSize-1:0] srcA;
      logic [regSize-1:0] srcB;
      logic [2:0]         op;
      logic [AW-1:0]      dest;
      logic [AW-1:0]      addrA;
      logic [AW-1:0]      addrB;
      logic               immSel;
   } held_t;

   logic [regSize-1:0] modelRegs [regCount];
   held_t              model;

   function automatic logic [regSize-1:0] modelRead(input logic [AW-1:0] addr);
`ifdef WRITE_BYPASS_EN
      if (WrEn && WrAddr == addr) return WrData;
`endif
      return modelRegs[addr];
   endfunction

   // Evaluate what the stage must hold after each edge, then commit the writeback
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < regCount; i++) modelRegs[i] = '0;
         model = '0;
      end else begin
         if (Flush) begin
            model = '0;
         end else if (Stall) begin
`ifdef WRITE_BYPASS_EN
            if (model.valid && WrEn && WrAddr == model.addrA) model.srcA = WrData;
            if (model.valid && WrEn && WrAddr == model.addrB && !model.immSel) model.srcB = WrData;
`endif
         end else if (InValid) begin
            model = '{valid: 1'b1, srcA: modelRead(RdAddrA),
                      srcB: ImmSel ? Imm : modelRead(RdAddrB), op: ALUOpIn,
                      dest: DestIn, addrA: RdAddrA, addrB: RdAddrB, immSel: ImmSel};
         end else begin
            model = '0;
         end
         if (WrEn) modelRegs[WrAddr] = WrData;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Continuous comparison against the model, mid-cycle, whenever out of reset
   always @(negedge Clk) begin
      if (Reset_n === 1'b1) begin
         checkOutput("OutValid", 32'(OutValid), 32'(model.valid));
         checkOutput("SrcA", 32'(SrcA), 32'(model.srcA));
         checkOutput("SrcB", 32'(SrcB), 32'(model.srcB));
         checkOutput("ALUOp", 32'(ALUOp), 32'(model.op));
         checkOutput("DestOut", 32'(DestOut), 32'(model.dest));
         checkOutput("InReady", 32'(InReady), 32'(!Stall));
      end
   end

   // Advance one edge; inputs may then be changed safely away from the edge
   task automatic applyStimulus();
      @(posedge Clk);
      #2;
   endtask

   task automatic clearInputs();
      InValid = 0; RdAddrA = 0; RdAddrB = 0; ImmSel = 0; Imm = 0; ALUOpIn = 0;
      DestIn = 0; WrEn = 0; WrAddr = 0; WrData = 0; Stall = 0; Flush = 0;
   endtask

   logic [regSize-1:0] expBypass, expRefresh;

   initial begin
`ifdef WRITE_BYPASS_EN
      expBypass  = 8'hC3;
      expRefresh = 8'h20;
`else
      expBypass  = 8'h11;
      expRefresh = 8'h10;
`endif
      clearInputs();
      Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #2;
      checkOutput("reset OutValid", 32'(OutValid), 32'h0);
      checkOutput("reset SrcA", 32'(SrcA), 32'h0);
      Reset_n = 1'b1;

      // Basic fetch: r3 = 0x5A, then SrcA from r3 and SrcB from immediate
      WrEn = 1; WrAddr = 3; WrData = 8'h5A;
      applyStimulus();
      WrEn = 0; InValid = 1; RdAddrA = 3; ImmSel = 1; Imm = 8'h07; ALUOpIn = 3'b001; DestIn = 5;
      applyStimulus();
      checkOutput("fetch SrcA", 32'(SrcA), 32'h5A);
      checkOutput("fetch SrcB", 32'(SrcB), 32'h07);
      checkOutput("fetch ALUOp", 32'(ALUOp), 32'h1);
      checkOutput("fetch DestOut", 32'(DestOut), 32'h5);
      checkOutput("fetch OutValid", 32'(OutValid), 32'h1);

      // Same-cycle write and read of r2
      clearInputs();
      WrEn = 1; WrAddr = 2; WrData = 8'h11;
      applyStimulus();
      WrData = 8'hC3; InValid = 1; RdAddrB = 2; ImmSel = 0; ALUOpIn = 3'b011; DestIn = 2;
      applyStimulus();
      checkOutput("bypass SrcB", 32'(SrcB), 32'(expBypass));

      // Stall hold and refresh: SrcA from r4, immediate SrcB must never be refreshed
      clearInputs();
      WrEn = 1; WrAddr = 4; WrData = 8'h10;
      applyStimulus();
      WrEn = 0; InValid = 1; RdAddrA = 4; RdAddrB = 4; ImmSel = 1; Imm = 8'h33; ALUOpIn = 3'b010;
      applyStimulus();
      checkOutput("stall load SrcA", 32'(SrcA), 32'h10);
      Stall = 1; RdAddrA = 1; RdAddrB = 1; ImmSel = 0;
      applyStimulus();
      WrEn = 1; WrAddr = 4; WrData = 8'h20;
      applyStimulus();
      WrEn = 0;
      applyStimulus();
      checkOutput("stall SrcA", 32'(SrcA), 32'(expRefresh));
      checkOutput("stall SrcB", 32'(SrcB), 32'h33);
      checkOutput("stall OutValid", 32'(OutValid), 32'h1);
      checkOutput("stall InReady", 32'(InReady), 32'h0);

      // Flush beats stall, and the concurrent writeback still lands
      Flush = 1; WrEn = 1; WrAddr = 6; WrData = 8'h77;
      applyStimulus();
      checkOutput("flush OutValid", 32'(OutValid), 32'h0);
      checkOutput("flush SrcA", 32'(SrcA), 32'h0);
      checkOutput("flush SrcB", 32'(SrcB), 32'h0);
      checkOutput("flush ALUOp", 32'(ALUOp), 32'h0);
      clearInputs();
      InValid = 1; RdAddrA = 6; ImmSel = 1;
      applyStimulus();
      checkOutput("flush write SrcA", 32'(SrcA), 32'h77);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         InValid = ($urandom_range(3) != 0);
         RdAddrA = AW'($urandom);
         RdAddrB = AW'($urandom);
         ImmSel  = 1'($urandom);
         Imm     = regSize'($urandom);
         ALUOpIn = 3'($urandom);
         DestIn  = AW'($urandom);
         WrEn    = 1'($urandom);
         WrAddr  = AW'($urandom);
         WrData  = regSize'($urandom);
         Stall   = ($urandom_range(3) == 0);
         Flush   = ($urandom_range(9) == 0);
         applyStimulus();
      end

      // Asynchronous reset mid-cycle, then every register must read back zero
      clearInputs();
      #1 Reset_n = 1'b0;
      #1;
      checkOutput("async reset OutValid", 32'(OutValid), 32'h0);
      checkOutput("async reset SrcA", 32'(SrcA), 32'h0);
      checkOutput("async reset SrcB", 32'(SrcB), 32'h0);
      applyStimulus();
      Reset_n = 1'b1;
      for (int i = 0; i < regCount; i++) begin
         InValid = 1; ImmSel = 0; RdAddrA = AW'(i); RdAddrB = AW'(regCount - 1 - i);
         applyStimulus();
         checkOutput("post-reset SrcA", 32'(SrcA), 32'h0);
         checkOutput("post-reset SrcB", 32'(SrcB), 32'h0);
      end

      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
